glyph_dma_arbiter: RTL and testbench
====================================

GLYPH_DMA_ARBITER -- requirements
Module: glyph_dma_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 5: number of sprite requesters.
REQ-002 SHALL have parameter CORDW, default 16: signed screen-coordinate width.
REQ-003 SHALL have parameter FONT_HEIGHT, default 16: glyph rows; power of two.
REQ-004 SHALL have parameter ADDRW, default 11: font ROM address width.
REQ-005 SHALL have parameter WIN_START, default -10: signed sx value on which the DMA window opens.
REQ-006 SHALL have parameter WIN_LEN, default 10: DMA window length in clk_pix cycles; must be ≥ 1.
REQ-007 SHALL have port clk_pix, input, 1 bit: pixel clock; the only clock.
REQ-008 SHALL have port rst_pix_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port line, input, 1 bit: one-cycle start-of-line pulse.
REQ-010 SHALL have port sx, input, CORDW bits, signed: current horizontal position.
REQ-011 SHALL have port req, input, N_REQ bits: per-sprite request for one glyph row this line.
REQ-012 SHALL have port req_cp, input, N_REQ×ADDRW bits: per-sprite normalised glyph code.
REQ-013 SHALL have port req_row, input, N_REQ×log2(FONT_HEIGHT) bits: per-sprite glyph row.
REQ-014 SHALL have port grant, output, N_REQ bits: one-hot or zero, drives the sprite dma_avail.
REQ-015 SHALL have port rom_addr, output, ADDRW bits: font ROM address.
REQ-016 SHALL have port busy, output, 1 bit: high while in WINDOW.
REQ-017 SHALL have port miss, output, 1 bit: one-cycle pulse when a request goes unserved at window close.
REQ-018 SHALL have port miss_cnt, output, 8 bits: saturating count of miss pulses.

Function
REQ-019 SHALL implement FSM IDLE -> WINDOW (sx == WIN_START) -> IDLE (after WIN_LEN cycles in WINDOW, tracked by a window counter).
REQ-020 SHALL, in each WINDOW cycle, grant the requester i with req[i] set and served[i] clear that is first in round-robin order from rr_ptr; otherwise it SHALL grant none.
REQ-021 SHALL register grant and rom_addr together, so a winner chosen in cycle t appears on grant and rom_addr in cycle t+1; ROM data returns in cycle t+2.
REQ-022 SHALL compute rom_addr = FONT_HEIGHT*req_cp[i] + req_row[i], truncated to ADDRW, and SHALL hold rom_addr at 0 when grant is zero.
REQ-023 SHALL grant each requester at most once per line, by setting served[i] when it wins.
REQ-024 SHALL, on window close, pulse miss for one cycle and increment miss_cnt (saturating at 255) if any req[i] is set with served[i] clear.
REQ-025 SHALL, on line, clear served, advance rr_ptr by 1 modulo N_REQ, and force IDLE; a line pulse during WINDOW SHALL abort the window without a miss.
REQ-026 SHALL treat line and sx == WIN_START in the same cycle as line only: the window does not open that cycle.
REQ-027 SHALL not grant a requester whose req drops before it wins; that requester SHALL not count as a miss.
REQ-028 SHALL keep the final-cycle winner's grant one cycle past window close, per REQ-021 latency; no new arbitration occurs after close.

Reset
REQ-029 SHALL, while rst_pix_n is low, immediately set state IDLE, grant 0, rom_addr 0, busy 0, miss 0, miss_cnt 0, served 0 and rr_ptr 0.
REQ-030 SHALL, when reset is asserted mid-window, drop grant within the same cycle and re-arm only at the next sx == WIN_START after release.

Structure
REQ-031 SHALL place the FSM state enum and the miss_cnt width in the shared display package.
REQ-032 SHALL factor the masked round-robin priority pick (req & ~served, rr_ptr) -> one-hot into the combinational sub-module rr_pick.

Verification
REQ-033 SHALL verify: N_REQ=5, rr_ptr=0, all req high, req_cp={12,52,2A,20,2E} hex, row 3 -> grants 0..4 in consecutive cycles starting at sx=-9; rom_addr=123,523,2A3,203,2E3 hex; no miss.
REQ-034 SHALL verify: second line, same stimulus -> grant order 1,2,3,4,0.
REQ-035 SHALL verify: WIN_LEN=3, five requests -> three grants, one miss pulse at close, miss_cnt=1.
REQ-036 SHALL verify: req[2] alone held through the window -> exactly one grant, then grant 0 for the rest of the line.
REQ-037 SHALL verify: rst_pix_n low at the third window cycle -> grant and rom_addr go 0 asynchronously; after release nothing is granted until the next window.
REQ-038 SHALL verify: 300 forced misses -> miss_cnt saturates at 255.

Source files
------------

// File: rtl/glyph_dma_arbiter_pkg.sv
// Shared definitions for the glyph DMA arbiter: FSM state encoding, miss counter
// width and a pointer-width helper.
package glyph_dma_arbiter_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      WINDOW = 1'b1
   } arb_state_t;

   localparam int MISS_CNT_W = 8;

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/glyph_dma_arbiter_rr_pick.sv
// Round-robin priority pick: first set bit of req_m at or after ptr (wrapping)
// comes out one-hot on pick; zero when req_m is empty.
module rr_pick
   import glyph_dma_arbiter_pkg::*;
#(
   parameter int N_REQ = 5,
   parameter int PW    = ptr_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req_m,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] pick
);

   logic [PW-1:0] idx;
   logic          found;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = ptr;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && req_m[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
         idx = (idx == PW'(N_REQ - 1)) ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/glyph_dma_arbiter.sv
// Per-line font ROM arbiter for sprite glyph fetches: opens a short DMA window at
// sx == WIN_START and grants each requesting sprite one ROM read per line.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for sx == WIN_START; no arbitration
// WINDOW | WIN_LEN cycles of round-robin arbitration, one winner per cycle
module glyph_dma_arbiter
   import glyph_dma_arbiter_pkg::*;
#(
   parameter int N_REQ       = 5,
   parameter int CORDW       = 16,
   parameter int FONT_HEIGHT = 16,
   parameter int ADDRW       = 11,
   parameter int WIN_START   = -10,
   parameter int WIN_LEN     = 10,
   localparam int ROWW       = $clog2(FONT_HEIGHT)
) (
   input  logic                    clk_pix,
   input  logic                    rst_pix_n,
   input  logic                    line,
   input  logic signed [CORDW-1:0] sx,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDRW-1:0]  req_cp,
   input  logic [N_REQ*ROWW-1:0]   req_row,
   output logic [N_REQ-1:0]        grant,
   output logic [ADDRW-1:0]        rom_addr,
   output logic                    busy,
   output logic                    miss,
   output logic [MISS_CNT_W-1:0]   miss_cnt
);

   localparam int PW  = ptr_w(N_REQ);
   localparam int WCW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam logic signed [CORDW-1:0] WIN_START_C = CORDW'(WIN_START);

   arb_state_t            state_q, state_d;
   logic [WCW-1:0]        win_cnt_q, win_cnt_d;
   logic [N_REQ-1:0]      served_q, served_d;
   logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [N_REQ-1:0]      grant_q, grant_d;
   logic [ADDRW-1:0]      rom_addr_q, rom_addr_d;
   logic                  miss_q, miss_d;
   logic [MISS_CNT_W-1:0] miss_cnt_q, miss_cnt_d;

   logic [N_REQ-1:0]      req_m;
   logic [N_REQ-1:0]      pick;
   logic [ADDRW-1:0]      addr_sel;

   assign req_m = req & ~served_q;

   rr_pick #(
      .N_REQ (N_REQ),
      .PW    (PW)
   ) u_rr_pick (
      .req_m (req_m),
      .ptr   (rr_ptr_q),
      .pick  (pick)
   );

   // pick is one-hot, so at most one term lands here
   always_comb begin
      addr_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick[i]) begin
            addr_sel = ADDRW'({req_cp[i*ADDRW +: ADDRW], req_row[i*ROWW +: ROWW]});
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      win_cnt_d  = win_cnt_q;
      served_d   = served_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = '0;
      rom_addr_d = '0;
      miss_d     = 1'b0;
      miss_cnt_d = miss_cnt_q;
      if (line) begin
         state_d  = IDLE;
         served_d = '0;
         rr_ptr_d = (rr_ptr_q == PW'(N_REQ - 1)) ? '0 : rr_ptr_q + 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (sx == WIN_START_C) begin
                  state_d   = WINDOW;
                  win_cnt_d = WCW'(WIN_LEN - 1);
               end
            end
            WINDOW: begin
               grant_d    = pick;
               rom_addr_d = addr_sel;
               served_d   = served_q | pick;
               if (win_cnt_q == '0) begin
                  state_d = IDLE;
                  // this cycle's winner is served; anything else still asking missed
                  if (|(req & ~served_q & ~pick)) begin
                     miss_d = 1'b1;
                     if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
                  end
               end else begin
                  win_cnt_d = win_cnt_q - 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         state_q    <= IDLE;
         win_cnt_q  <= '0;
         served_q   <= '0;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         rom_addr_q <= '0;
         miss_q     <= 1'b0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         win_cnt_q  <= win_cnt_d;
         served_q   <= served_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         rom_addr_q <= rom_addr_d;
         miss_q     <= miss_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign grant    = grant_q;
   assign rom_addr = rom_addr_q;
   assign busy     = (state_q == WINDOW);
   assign miss     = miss_q;
   assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_glyph_dma_arbiter.sv
// Directed bench for glyph_dma_arbiter: a default instance (WIN_LEN=10) and a
// short-window instance (WIN_LEN=3) share all inputs.
module tb_glyph_dma_arbiter;

   logic               clk_pix = 1'b0;
   logic               rst_pix_n;
   logic               line;
   logic signed [15:0] sx;
   logic [4:0]         req;
   logic [54:0]        req_cp;
   logic [19:0]        req_row;

   logic [4:0]  grant, grant3;
   logic [10:0] rom_addr, rom_addr3;
   logic        busy, busy3, miss, miss3;
   logic [7:0]  miss_cnt, miss_cnt3;

   int tests = 0;
   int fails = 0;

   // per-sweep logs, indexed by (sx value sampled at the edge) + 16
   logic [4:0]  g_log  [32];
   logic [10:0] a_log  [32];
   logic        b_log  [32];
   logic        m_log  [32];
   logic [4:0]  g3_log [32];
   logic        b3_log [32];
   logic        m3_log [32];

   logic [10:0] addr_tab [5];
   int          ord2 [5];

   always #5 clk_pix = ~clk_pix;

   glyph_dma_arbiter dut (
      .clk_pix   (clk_pix),
      .rst_pix_n (rst_pix_n),
      .line      (line),
      .sx        (sx),
      .req       (req),
      .req_cp    (req_cp),
      .req_row   (req_row),
      .grant     (grant),
      .rom_addr  (rom_addr),
      .busy      (busy),
      .miss      (miss),
      .miss_cnt  (miss_cnt)
   );

   glyph_dma_arbiter #(.WIN_LEN(3)) dut3 (
      .clk_pix   (clk_pix),
      .rst_pix_n (rst_pix_n),
      .line      (line),
      .sx        (sx),
      .req       (req),
      .req_cp    (req_cp),
      .req_row   (req_row),
      .grant     (grant3),
      .rom_addr  (rom_addr3),
      .busy      (busy3),
      .miss      (miss3),
      .miss_cnt  (miss_cnt3)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_pix);
      #1;
   endtask

   // optional line pulse, then sweep sx from -12 to 4; rst_at pulses reset mid-cycle
   task automatic run_line(input bit do_line, input int rst_at);
      if (do_line) begin
         line = 1'b1;
         sx   = -16'sd30;
         tick();
         line = 1'b0;
      end
      for (int s = -12; s <= 4; s++) begin
         sx = 16'(s);
         if (s == rst_at) begin
            #3;
            chk("pre_rst_grant", 32'(grant), 32'(5'b10000));
            rst_pix_n = 1'b0;
            #1;
            chk("rst_async_grant", 32'(grant), 32'd0);
            chk("rst_async_addr", 32'(rom_addr), 32'd0);
            chk("rst_async_busy", 32'(busy), 32'd0);
            #2;
            rst_pix_n = 1'b1;
         end
         tick();
         g_log[s+16]  = grant;
         a_log[s+16]  = rom_addr;
         b_log[s+16]  = busy;
         m_log[s+16]  = miss;
         g3_log[s+16] = grant3;
         b3_log[s+16] = busy3;
         m3_log[s+16] = miss3;
      end
   endtask

   task automatic short_line();
      line = 1'b1;
      sx   = -16'sd30;
      tick();
      line = 1'b0;
      for (int s = -10; s <= -7; s++) begin
         sx = 16'(s);
         tick();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic any;
      addr_tab[0] = 11'h123; addr_tab[1] = 11'h523; addr_tab[2] = 11'h2A3;
      addr_tab[3] = 11'h203; addr_tab[4] = 11'h2E3;
      ord2[0] = 1; ord2[1] = 2; ord2[2] = 3; ord2[3] = 4; ord2[4] = 0;

      rst_pix_n = 1'b0;
      line      = 1'b0;
      sx        = -16'sd30;
      req       = '0;
      req_cp    = {11'h02E, 11'h020, 11'h02A, 11'h052, 11'h012};
      req_row   = {5{4'd3}};
      repeat (3) tick();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_addr", 32'(rom_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_miss", 32'(miss), 32'd0);
      chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
      chk("rst_miss_cnt3", 32'(miss_cnt3), 32'd0);
      rst_pix_n = 1'b1;
      tick();

      // line 1: rr_ptr=0, winners chosen at sx=-9..-5 are 0..4
      req = 5'b11111;
      run_line(1'b0, 99);
      for (int k = 0; k < 5; k++) begin
         chk("l1_grant", 32'(g_log[-9+k+16]), 32'(1) << k);
         chk("l1_addr", 32'(a_log[-9+k+16]), 32'(addr_tab[k]));
      end
      for (int s = -4; s <= 4; s++) chk("l1_grant_idle", 32'(g_log[s+16]), 32'd0);
      chk("l1_busy_pre", 32'(b_log[-11+16]), 32'd0);
      chk("l1_busy_open", 32'(b_log[-10+16]), 32'd1);
      chk("l1_busy_last", 32'(b_log[-1+16]), 32'd1);
      chk("l1_busy_close", 32'(b_log[0+16]), 32'd0);
      any = 1'b0;
      for (int s = -12; s <= 4; s++) any |= m_log[s+16];
      chk("l1_no_miss", 32'(any), 32'd0);
      // short window: three grants, last one visible one cycle past close, then miss
      chk("w3_l1_g0", 32'(g3_log[-9+16]), 32'(5'b00001));
      chk("w3_l1_g1", 32'(g3_log[-8+16]), 32'(5'b00010));
      chk("w3_l1_g2", 32'(g3_log[-7+16]), 32'(5'b00100));
      chk("w3_l1_busy_close", 32'(b3_log[-7+16]), 32'd0);
      chk("w3_l1_g_after", 32'(g3_log[-6+16]), 32'd0);
      chk("w3_l1_miss_early", 32'(m3_log[-8+16]), 32'd0);
      chk("w3_l1_miss", 32'(m3_log[-7+16]), 32'd1);
      chk("w3_l1_miss_pulse", 32'(m3_log[-6+16]), 32'd0);
      chk("w3_l1_miss_cnt", 32'(miss_cnt3), 32'd1);

      // line 2: rr_ptr advanced to 1
      run_line(1'b1, 99);
      for (int k = 0; k < 5; k++) begin
         chk("l2_grant", 32'(g_log[-9+k+16]), 32'(1) << ord2[k]);
         chk("l2_addr", 32'(a_log[-9+k+16]), 32'(addr_tab[ord2[k]]));
      end
      chk("l2_grant_idle", 32'(g_log[-4+16]), 32'd0);
      chk("l2_miss_cnt", 32'(miss_cnt), 32'd0);
      chk("w3_l2_g0", 32'(g3_log[-9+16]), 32'(5'b00010));
      chk("w3_l2_g2", 32'(g3_log[-7+16]), 32'(5'b01000));
      chk("w3_l2_miss_cnt", 32'(miss_cnt3), 32'd2);

      // line 3: only requester 2 asks
      req = 5'b00100;
      run_line(1'b1, 99);
      chk("solo_grant", 32'(g_log[-9+16]), 32'(5'b00100));
      chk("solo_addr", 32'(a_log[-9+16]), 32'(11'h2A3));
      any = 1'b0;
      for (int s = -8; s <= 4; s++) any |= (g_log[s+16] != 5'b0);
      chk("solo_rest_zero", 32'(any), 32'd0);
      chk("solo_w3_miss", 32'(m3_log[-7+16]), 32'd0);
      chk("solo_w3_miss_cnt", 32'(miss_cnt3), 32'd2);

      // line 4: rr_ptr=3, reset during third window cycle (sx=-7)
      req = 5'b11111;
      run_line(1'b1, -7);
      chk("rst_l4_g0", 32'(g_log[-9+16]), 32'(5'b01000));
      chk("rst_l4_g1", 32'(g_log[-8+16]), 32'(5'b10000));
      any = 1'b0;
      for (int s = -7; s <= 4; s++) any |= (g_log[s+16] != 5'b0) | b_log[s+16];
      chk("rst_no_regrant", 32'(any), 32'd0);
      chk("rst_miss_cnt3_clr", 32'(miss_cnt3), 32'd0);

      // re-arm with no line pulse: rr_ptr back to 0
      run_line(1'b0, 99);
      chk("rearm_grant", 32'(g_log[-9+16]), 32'(5'b00001));
      chk("rearm_addr", 32'(a_log[-9+16]), 32'(11'h123));
      chk("rearm_w3_miss_cnt", 32'(miss_cnt3), 32'd1);

      // line and sx == WIN_START together: no window
      line = 1'b1;
      sx   = -16'sd10;
      tick();
      line = 1'b0;
      any  = 1'b0;
      for (int s = -9; s <= 2; s++) begin
         sx = 16'(s);
         tick();
         any |= busy | busy3 | (grant != 5'b0) | (grant3 != 5'b0);
      end
      chk("line_wins_over_open", 32'(any), 32'd0);
      chk("line_open_miss_cnt3", 32'(miss_cnt3), 32'd1);

      // 300 forced misses on the short window
      repeat (253) short_line();
      chk("sat_254", 32'(miss_cnt3), 32'd254);
      short_line();
      chk("sat_255", 32'(miss_cnt3), 32'd255);
      repeat (46) short_line();
      chk("sat_hold", 32'(miss_cnt3), 32'd255);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
